// File: rtl/viterbi_acs_scheduler.sv
// Trellis-step sequencer for the Viterbi add-compare-select datapath: issues one
// butterfly per cycle, aligns metric/survivor write strobes to ACS latency, swaps banks.
module viterbi_acs_scheduler #(
  parameter int NUM_BFLY = 32,
  parameter int ADDR_W   = 5,
  parameter int ACS_LAT  = 2,
  parameter int STEP_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sym_valid,
  output logic              sym_ready,
  input  logic              frame_start,
  input  logic              acs_beyond,
  output logic              acs_in_ena,
  output logic              acs_is_uniform,
  output logic [ADDR_W-1:0] bfly_idx,
  output logic              rd_bank,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_bank,
  output logic              step_done,
  output logic [STEP_W-1:0] step_cnt,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, SWAP} state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(NUM_BFLY - 1);
  localparam logic [2:0]        LAST_DRAIN = 3'(ACS_LAT - 1);

  state_t            state, state_nxt;
  logic              accept;
  logic              norm_pending;
  logic [2:0]        drain_cnt;
  logic [ACS_LAT-1:0] dl_ena;
  logic [ADDR_W-1:0] dl_idx [ACS_LAT];

  assign accept = sym_valid & sym_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block is assigned a default before the case so
  // no path leaves a variable unassigned, which would infer a latch.
  always_comb begin
    state_nxt  = state;
    sym_ready  = 1'b0;
    acs_in_ena = 1'b0;
    step_done  = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        sym_ready = 1'b1;
        busy      = 1'b0;
        if (sym_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        acs_in_ena = 1'b1;
        if (bfly_idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt == LAST_DRAIN) state_nxt = SWAP;
      end
      SWAP: begin
        step_done = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Step-level registers. The normalization offset is latched only at symbol
  // acceptance so the ACS never sees it change in the middle of a step.
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      bfly_idx       <= '0;
      drain_cnt      <= '0;
      acs_is_uniform <= 1'b0;
      norm_pending   <= 1'b0;
      rd_bank        <= 1'b0;
      step_cnt       <= '0;
    end else begin
      if (accept) begin
        bfly_idx     <= '0;
        norm_pending <= 1'b0;
        if (frame_start) begin
          rd_bank        <= 1'b0;
          step_cnt       <= '0;
          acs_is_uniform <= 1'b0;
        end else begin
          acs_is_uniform <= norm_pending;
        end
      end else if ((state == ISSUE || state == DRAIN) && acs_beyond) begin
        norm_pending <= 1'b1;
      end

      if (state == ISSUE)
        bfly_idx <= (bfly_idx == LAST_IDX) ? '0 : bfly_idx + ADDR_W'(1);

      drain_cnt <= (state == DRAIN) ? drain_cnt + 3'd1 : 3'd0;

      if (state == SWAP) begin
        rd_bank  <= ~rd_bank;
        step_cnt <= step_cnt + STEP_W'(1);
      end
    end
  end

  // NOTE: this delay line is reset on purpose: a reset mid-step must discard
  // in-flight writes, so stale entries may not reach wr_en.
  always_ff @(posedge clk) begin
    if (rst) begin
      dl_ena <= '0;
      for (int i = 0; i < ACS_LAT; i++) dl_idx[i] <= '0;
    end else begin
      dl_ena[0] <= acs_in_ena;
      dl_idx[0] <= bfly_idx;
      for (int i = 1; i < ACS_LAT; i++) begin
        dl_ena[i] <= dl_ena[i-1];
        dl_idx[i] <= dl_idx[i-1];
      end
    end
  end

  assign wr_en   = dl_ena[ACS_LAT-1];
  assign wr_addr = dl_idx[ACS_LAT-1];
  assign wr_bank = ~rd_bank;

endmodule

// File: tb/tb_viterbi_acs_scheduler.sv
// Scoreboard bench for viterbi_acs_scheduler: stimulus pushes cycle-stamped expected
// issues/writes/step completions; negedge monitors pop and compare.
module tb_viterbi_acs_scheduler;

  localparam int N  = 32;
  localparam int L  = 2;
  localparam int NB = 4;
  localparam int LB = 5;

  typedef struct {int cyc; int val; int bank; int uni;} exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: default geometry
  logic        sym_valid = 1'b0, frame_start = 1'b0, acs_beyond = 1'b0;
  logic        sym_ready, acs_in_ena, acs_is_uniform, rd_bank, wr_en, wr_bank, step_done, busy;
  logic [4:0]  bfly_idx, wr_addr;
  logic [15:0] step_cnt;

  viterbi_acs_scheduler #(.NUM_BFLY(N), .ADDR_W(5), .ACS_LAT(L), .STEP_W(16)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_ready(sym_ready),
    .frame_start(frame_start), .acs_beyond(acs_beyond), .acs_in_ena(acs_in_ena),
    .acs_is_uniform(acs_is_uniform), .bfly_idx(bfly_idx), .rd_bank(rd_bank),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_bank(wr_bank), .step_done(step_done),
    .step_cnt(step_cnt), .busy(busy)
  );

  // Instance B: small trellis, long ACS latency
  logic        b_sym_valid = 1'b0;
  logic        b_frame_start = 1'b0, b_acs_beyond = 1'b0;
  logic        b_sym_ready, b_acs_in_ena, b_acs_is_uniform, b_rd_bank, b_wr_en, b_wr_bank;
  logic        b_step_done, b_busy;
  logic [1:0]  b_bfly_idx, b_wr_addr;
  logic [15:0] b_step_cnt;

  viterbi_acs_scheduler #(.NUM_BFLY(NB), .ADDR_W(2), .ACS_LAT(LB), .STEP_W(16)) dut_b (
    .clk(clk), .rst(rst), .sym_valid(b_sym_valid), .sym_ready(b_sym_ready),
    .frame_start(b_frame_start), .acs_beyond(b_acs_beyond), .acs_in_ena(b_acs_in_ena),
    .acs_is_uniform(b_acs_is_uniform), .bfly_idx(b_bfly_idx), .rd_bank(b_rd_bank),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_bank(b_wr_bank), .step_done(b_step_done),
    .step_cnt(b_step_cnt), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  exp_t iss_q[$], wr_q[$], done_q[$], b_iss_q[$], b_wr_q[$], b_done_q[$];
  exp_t ea, eb;
  int   m_step = 0, m_bank = 0, m_pending = 0;
  int   busy_lo = 0, busy_hi = -1;
  int   bm_step = 0, bm_bank = 0;
  int   b_busy_lo = 0, b_busy_hi = -1;
  bit   mon_en = 1'b0;

  always @(negedge clk) if (mon_en) begin
    check("sym_ready", sym_ready, !(cyc >= busy_lo && cyc <= busy_hi));
    check("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
    check("wr_bank", wr_bank, !rd_bank);
    if (acs_in_ena) begin
      if (iss_q.size() == 0) check("acs_in_ena unexpected", 1, 0);
      else begin
        ea = iss_q.pop_front();
        check("issue cycle", cyc, ea.cyc);
        check("bfly_idx", bfly_idx, ea.val);
        check("acs_is_uniform", acs_is_uniform, ea.uni);
        check("rd_bank in step", rd_bank, ea.bank);
      end
    end else if (iss_q.size() > 0 && iss_q[0].cyc <= cyc) begin
      check("acs_in_ena missing", 0, 1);
      void'(iss_q.pop_front());
    end
    if (wr_en) begin
      if (wr_q.size() == 0) check("wr_en unexpected", 1, 0);
      else begin
        ea = wr_q.pop_front();
        check("write cycle", cyc, ea.cyc);
        check("wr_addr", wr_addr, ea.val);
        check("wr_bank in write", wr_bank, ea.bank);
        check("acs_is_uniform in write", acs_is_uniform, ea.uni);
      end
    end else if (wr_q.size() > 0 && wr_q[0].cyc <= cyc) begin
      check("wr_en missing", 0, 1);
      void'(wr_q.pop_front());
    end
    if (step_done) begin
      if (done_q.size() == 0) check("step_done unexpected", 1, 0);
      else begin
        ea = done_q.pop_front();
        check("step_done cycle", cyc, ea.cyc);
        check("step_cnt at swap", step_cnt, ea.val);
        check("rd_bank at swap", rd_bank, ea.bank);
        check("acs_is_uniform at swap", acs_is_uniform, ea.uni);
      end
    end else if (done_q.size() > 0 && done_q[0].cyc <= cyc) begin
      check("step_done missing", 0, 1);
      void'(done_q.pop_front());
    end
  end

  always @(negedge clk) if (mon_en) begin
    check("b sym_ready", b_sym_ready, !(cyc >= b_busy_lo && cyc <= b_busy_hi));
    if (b_acs_in_ena) begin
      if (b_iss_q.size() == 0) check("b acs_in_ena unexpected", 1, 0);
      else begin
        eb = b_iss_q.pop_front();
        check("b issue cycle", cyc, eb.cyc);
        check("b bfly_idx", b_bfly_idx, eb.val);
      end
    end else if (b_iss_q.size() > 0 && b_iss_q[0].cyc <= cyc) begin
      check("b acs_in_ena missing", 0, 1);
      void'(b_iss_q.pop_front());
    end
    if (b_wr_en) begin
      if (b_wr_q.size() == 0) check("b wr_en unexpected", 1, 0);
      else begin
        eb = b_wr_q.pop_front();
        check("b write cycle", cyc, eb.cyc);
        check("b wr_addr", b_wr_addr, eb.val);
        check("b wr_bank", b_wr_bank, eb.bank);
      end
    end else if (b_wr_q.size() > 0 && b_wr_q[0].cyc <= cyc) begin
      check("b wr_en missing", 0, 1);
      void'(b_wr_q.pop_front());
    end
    if (b_step_done) begin
      if (b_done_q.size() == 0) check("b step_done unexpected", 1, 0);
      else begin
        eb = b_done_q.pop_front();
        check("b step_done cycle", cyc, eb.cyc);
        check("b step_cnt at swap", b_step_cnt, eb.val);
      end
    end else if (b_done_q.size() > 0 && b_done_q[0].cyc <= cyc) begin
      check("b step_done missing", 0, 1);
      void'(b_done_q.pop_front());
    end
  end

  task automatic check_reset(input string tag);
    check({tag, " sym_ready"}, sym_ready, 1);
    check({tag, " acs_in_ena"}, acs_in_ena, 0);
    check({tag, " acs_is_uniform"}, acs_is_uniform, 0);
    check({tag, " bfly_idx"}, bfly_idx, 0);
    check({tag, " rd_bank"}, rd_bank, 0);
    check({tag, " wr_en"}, wr_en, 0);
    check({tag, " wr_addr"}, wr_addr, 0);
    check({tag, " wr_bank"}, wr_bank, 1);
    check({tag, " step_done"}, step_done, 0);
    check({tag, " step_cnt"}, step_cnt, 0);
    check({tag, " busy"}, busy, 0);
  endtask

  // Called #1 into a cycle in which the model says the scheduler is IDLE.
  task automatic issue_step(input bit fs, input int beyond_off, input bit keep_valid,
                            input int abort_at);
    int a;
    int uni;
    a = cyc;
    sym_valid   = 1'b1;
    frame_start = fs;
    if (fs) begin
      m_step = 0;
      m_bank = 0;
      uni    = 0;
    end else begin
      uni = m_pending;
    end
    m_pending = 0;
    for (int i = 0; i < N; i++) begin
      iss_q.push_back('{a + 1 + i, i, m_bank, uni});
      wr_q.push_back('{a + 1 + i + L, i, 1 - m_bank, uni});
    end
    done_q.push_back('{a + N + L + 1, m_step, m_bank, uni});
    busy_lo = a + 1;
    busy_hi = a + N + L + 1;
    while (cyc < a + N + L + 2) begin
      @(posedge clk); #1;
      sym_valid   = keep_valid;
      frame_start = 1'b0;
      acs_beyond  = (beyond_off >= 0 && cyc == a + 1 + beyond_off);
      if (acs_beyond) m_pending = 1;
      if (abort_at >= 0 && cyc == a + 1 + abort_at) rst = 1'b1;
      if (abort_at >= 0 && cyc == a + 2 + abort_at) begin
        rst        = 1'b0;
        acs_beyond = 1'b0;
        iss_q.delete();
        wr_q.delete();
        done_q.delete();
        m_step    = 0;
        m_bank    = 0;
        m_pending = 0;
        busy_hi   = -1;
        return;
      end
    end
    acs_beyond = 1'b0;
    m_step = (m_step + 1) & 16'hFFFF;
    m_bank = 1 - m_bank;
    check("step_cnt after step", step_cnt, m_step);
    check("rd_bank after step", rd_bank, m_bank);
  endtask

  task automatic idle(input int n, input bit beyond, input bit fs_pulse);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      sym_valid   = 1'b0;
      acs_beyond  = beyond;
      frame_start = fs_pulse;
    end
    @(posedge clk); #1;
    acs_beyond  = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic b_step(input bit keep);
    int a;
    a = cyc;
    b_sym_valid = 1'b1;
    for (int i = 0; i < NB; i++) begin
      b_iss_q.push_back('{a + 1 + i, i, bm_bank, 0});
      b_wr_q.push_back('{a + 1 + i + LB, i, 1 - bm_bank, 0});
    end
    b_done_q.push_back('{a + NB + LB + 1, bm_step, bm_bank, 0});
    b_busy_lo = a + 1;
    b_busy_hi = a + NB + LB + 1;
    while (cyc < a + NB + LB + 2) begin
      @(posedge clk); #1;
      b_sym_valid = keep;
    end
    bm_step++;
    bm_bank = 1 - bm_bank;
    check("b step_cnt after step", b_step_cnt, bm_step);
    check("b rd_bank after step", b_rd_bank, bm_bank);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    check("b reset sym_ready", b_sym_ready, 1);
    check("b reset wr_en", b_wr_en, 0);
    check("b reset wr_bank", b_wr_bank, 1);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    issue_step(1'b0, -1, 1'b0, -1);          // single step: bank 0->1, step_cnt 1
    idle(2, 1'b0, 1'b0);
    issue_step(1'b0, 10, 1'b1, -1);          // held sym_valid, beyond at ISSUE idx 10
    issue_step(1'b0, -1, 1'b1, -1);          // offset applied for this whole step
    issue_step(1'b0, -1, 1'b0, -1);          // offset gone again
    idle(3, 1'b1, 1'b1);                     // beyond and frame_start ignored in IDLE
    issue_step(1'b0, N + L - 1, 1'b0, -1);   // beyond in the last DRAIN cycle
    idle(1, 1'b0, 1'b0);
    issue_step(1'b1, -1, 1'b0, -1);          // frame_start overrides pending offset
    idle(1, 1'b0, 1'b0);
    issue_step(1'b0, 3, 1'b0, 15);           // reset at idx 15
    check_reset("post-abort");
    idle(L + 3, 1'b0, 1'b0);
    issue_step(1'b0, -1, 1'b0, -1);          // restart from idx 0, bank 0

    b_step(1'b1);
    b_step(1'b0);
    idle(LB + 3, 1'b0, 1'b0);

    check("issue queue drained", iss_q.size(), 0);
    check("write queue drained", wr_q.size(), 0);
    check("done queue drained", done_q.size(), 0);
    check("b issue queue drained", b_iss_q.size(), 0);
    check("b write queue drained", b_wr_q.size(), 0);
    check("b done queue drained", b_done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1);
  end

endmodule
